// File: rtl/memoria_pkg.sv
// memoria_pkg: shared definitions for the memory-game board and its game FSM.
//   game_state_t  - 4-bit state codes driven by the game FSM
//   card_status_t - per-slot status stored in the board table
//   N_CARDS/SYM_W - table geometry (16 slots, 8 pairs, 3-bit symbols)
//   home_sym()    - symbol held by a slot in the ordered (unshuffled) layout
package memoria_pkg;

  localparam int N_CARDS = 16;
  localparam int SYM_W   = 3;

  typedef enum logic [3:0] {
    INICIO         = 4'd0,
    MUESTRO        = 4'd1,
    OCULTA         = 4'd2,
    REVUELVE       = 4'd3,
    INICIO_JUEGO   = 4'd4,
    TURNO          = 4'd5,
    UNA_CARTA      = 4'd6,
    DOS_CARTAS     = 4'd7,
    MOSTRAR_RANDOM = 4'd8,
    NO_MAS_PAREJAS = 4'd9,
    CONCLUSION     = 4'd10
  } game_state_t;

  typedef enum logic [1:0] {
    HIDDEN  = 2'd0,
    FACEUP  = 2'd1,
    MATCHED = 2'd2
  } card_status_t;

  // Ordered layout: slots 2k and 2k+1 both hold symbol k.
  function automatic logic [SYM_W-1:0] home_sym(input int idx);
    return SYM_W'(idx >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
//   clk, rst (async, active-high) - clock and reset (state returns to SEED)
//   en                            - advance one step on this clock edge
//   value                         - current LFSR state
// SEED must be non-zero or the register locks up at all-zeros.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  logic feedback;

  // Taps at bit positions 16,14,13,11 (1-based) -> bits 15,13,12,10.
  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (en) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/memoria_board_ctrl.sv
// memoria_board_ctrl: board-side responder for the memory-game FSM.
// Owns the 16-slot card table (symbol + status) and performs whatever the
// current game state code asks for: preview, hide, shuffle, player picks,
// random completion picks and pair verification.
//   clk, rst           - clock, async active-high reset
//   state              - game FSM state code (game_state_t)
//   sel_valid/sel_idx  - player select pulse and chosen slot
//   rd_idx             - display read address
//   rd_sym/rd_status   - table contents at rd_idx, one cycle later
//   cartas_mostradas, cartas_ocultas, cartas_revueltas, se_eligio_carta,
//   carta_randomizada, cartas_verificadas - one-cycle done pulses
//   hubo_pareja        - match result, meaningful only with cartas_verificadas
//   pairs_left         - unmatched pairs remaining (8..0)
//
// Handshake: each done output is a registered pulse, high for exactly one
// cycle, issued at most once per entry into the requesting state. The game
// FSM moves on when it sees the pulse. A state change before the pulse is
// issued abandons the operation silently. sel_valid is a request with no
// back-pressure: it is either accepted (se_eligio_carta next cycle) or
// dropped without any response.
module memoria_board_ctrl
  import memoria_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES   = 50_000_000,
  parameter int unsigned VERIFY_CYCLES = 25_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       sel_valid,
  input  logic [3:0] sel_idx,
  input  logic [3:0] rd_idx,
  output logic [2:0] rd_sym,
  output logic [1:0] rd_status,
  output logic       cartas_mostradas,
  output logic       cartas_ocultas,
  output logic       cartas_revueltas,
  output logic       se_eligio_carta,
  output logic       carta_randomizada,
  output logic       cartas_verificadas,
  output logic       hubo_pareja,
  output logic [3:0] pairs_left
);

  localparam logic [31:0] SHOW_LIM   = SHOW_CYCLES;
  localparam logic [31:0] VERIFY_LIM = VERIFY_CYCLES;

  logic [SYM_W-1:0] sym    [N_CARDS];
  card_status_t     status [N_CARDS];

  logic [3:0]  prev_state;
  logic [31:0] sub_cnt;     // preview / verify timer
  logic [3:0]  shuf_i;      // Fisher-Yates position, walks 15 -> 1
  logic        op_done;     // current state's pulse already issued
  logic [1:0]  pick_cnt;
  logic [3:0]  pick0;
  logic [3:0]  pick1;

  logic [15:0] lfsr_q;
  logic        first;       // first cycle in the current state
  logic        done_eff;    // op_done as seen by this cycle's work
  logic [3:0]  cand;        // random slot candidate
  logic        lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (lfsr_q)
  );

  assign first       = (state != prev_state);
  assign done_eff    = first ? 1'b0 : op_done;
  assign cand        = lfsr_q[3:0];
  assign lfsr_unused = ^lfsr_q[15:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CARDS; i++) begin
        sym[i]    <= home_sym(i);
        status[i] <= HIDDEN;
      end
      prev_state         <= 4'd0;
      sub_cnt            <= '0;
      shuf_i             <= 4'd0;
      op_done            <= 1'b0;
      pick_cnt           <= 2'd0;
      pick0              <= 4'd0;
      pick1              <= 4'd0;
      rd_sym             <= '0;
      rd_status          <= '0;
      cartas_mostradas   <= 1'b0;
      cartas_ocultas     <= 1'b0;
      cartas_revueltas   <= 1'b0;
      se_eligio_carta    <= 1'b0;
      carta_randomizada  <= 1'b0;
      cartas_verificadas <= 1'b0;
      hubo_pareja        <= 1'b0;
      pairs_left         <= 4'd8;
    end else begin
      prev_state <= state;
      rd_sym     <= sym[rd_idx];
      rd_status  <= status[rd_idx];

      cartas_mostradas   <= 1'b0;
      cartas_ocultas     <= 1'b0;
      cartas_revueltas   <= 1'b0;
      se_eligio_carta    <= 1'b0;
      carta_randomizada  <= 1'b0;
      cartas_verificadas <= 1'b0;
      hubo_pareja        <= 1'b0;

      // Entering a new state discards any half-finished operation.
      if (first) begin
        sub_cnt <= '0;
        shuf_i  <= 4'd15;
        op_done <= 1'b0;
      end

      case (game_state_t'(state))
        INICIO: begin
          for (int i = 0; i < N_CARDS; i++) begin
            sym[i]    <= home_sym(i);
            status[i] <= HIDDEN;
          end
          pick_cnt   <= 2'd0;
          pairs_left <= 4'd8;
        end

        MUESTRO: begin
          if (first) begin
            for (int i = 0; i < N_CARDS; i++) begin
              if (status[i] != MATCHED) status[i] <= FACEUP;
            end
            sub_cnt <= 32'd1;
          end else if (!op_done) begin
            if (sub_cnt >= SHOW_LIM) begin
              cartas_mostradas <= 1'b1;
              op_done          <= 1'b1;
            end else begin
              sub_cnt <= sub_cnt + 32'd1;
            end
          end
        end

        OCULTA: begin
          if (first) begin
            for (int i = 0; i < N_CARDS; i++) begin
              if (status[i] != MATCHED) status[i] <= HIDDEN;
            end
          end else if (!op_done) begin
            cartas_ocultas <= 1'b1;
            op_done        <= 1'b1;
          end
        end

        REVUELVE: begin
          // One candidate per cycle; out-of-range candidates are retried so
          // every j in 0..i stays equally likely.
          if (!first && !op_done && (cand <= shuf_i)) begin
            sym[shuf_i] <= sym[cand];
            sym[cand]   <= sym[shuf_i];
            if (shuf_i == 4'd1) begin
              cartas_revueltas <= 1'b1;
              op_done          <= 1'b1;
            end else begin
              shuf_i <= shuf_i - 4'd1;
            end
          end
        end

        INICIO_JUEGO: begin
          pick_cnt <= 2'd0;
        end

        TURNO, UNA_CARTA: begin
          // A still-high se_eligio_carta means the FSM has not reacted to
          // the previous pick yet, so a new select is dropped.
          if (sel_valid && (status[sel_idx] == HIDDEN) &&
              (pick_cnt < 2'd2) && !se_eligio_carta) begin
            status[sel_idx] <= FACEUP;
            if (pick_cnt == 2'd0) pick0 <= sel_idx;
            else                  pick1 <= sel_idx;
            pick_cnt        <= pick_cnt + 2'd1;
            se_eligio_carta <= 1'b1;
          end
        end

        DOS_CARTAS: begin
          if (first) begin
            sub_cnt <= 32'd1;
          end else if (!op_done) begin
            if (sub_cnt >= VERIFY_LIM) begin
              if (sym[pick0] == sym[pick1]) begin
                status[pick0] <= MATCHED;
                status[pick1] <= MATCHED;
                hubo_pareja   <= 1'b1;
                if (pairs_left != 4'd0) pairs_left <= pairs_left - 4'd1;
              end else begin
                status[pick0] <= HIDDEN;
                status[pick1] <= HIDDEN;
              end
              cartas_verificadas <= 1'b1;
              pick_cnt           <= 2'd0;
              op_done            <= 1'b1;
            end else begin
              sub_cnt <= sub_cnt + 32'd1;
            end
          end
        end

        MOSTRAR_RANDOM: begin
          // Work starts on the first cycle; the pulse follows the cycle in
          // which pick_cnt is seen at 2.
          if (!done_eff) begin
            if (pick_cnt == 2'd2) begin
              carta_randomizada <= 1'b1;
              op_done           <= 1'b1;
            end else if (status[cand] == HIDDEN) begin
              status[cand] <= FACEUP;
              if (pick_cnt == 2'd0) pick0 <= cand;
              else                  pick1 <= cand;
              pick_cnt <= pick_cnt + 2'd1;
            end
          end
        end

        default: begin
          // NO_MAS_PAREJAS, CONCLUSION and unused codes hold the board.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_board_ctrl.sv
// tb_memoria_board_ctrl: directed-sequence bench for memoria_board_ctrl with
// randomized slot choices, checked against a table-level model of the board.
module tb_memoria_board_ctrl;

  localparam int SHOW   = 4;
  localparam int VERIFY = 2;
  localparam int HID = 0;
  localparam int FUP = 1;
  localparam int MAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state;
  logic       sel_valid;
  logic [3:0] sel_idx;
  logic [3:0] rd_idx;
  logic [2:0] rd_sym;
  logic [1:0] rd_status;
  logic       cartas_mostradas, cartas_ocultas, cartas_revueltas;
  logic       se_eligio_carta, carta_randomizada, cartas_verificadas;
  logic       hubo_pareja;
  logic [3:0] pairs_left;

  memoria_board_ctrl #(
    .SHOW_CYCLES   (SHOW),
    .VERIFY_CYCLES (VERIFY),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .state              (state),
    .sel_valid          (sel_valid),
    .sel_idx            (sel_idx),
    .rd_idx             (rd_idx),
    .rd_sym             (rd_sym),
    .rd_status          (rd_status),
    .cartas_mostradas   (cartas_mostradas),
    .cartas_ocultas     (cartas_ocultas),
    .cartas_revueltas   (cartas_revueltas),
    .se_eligio_carta    (se_eligio_carta),
    .carta_randomizada  (carta_randomizada),
    .cartas_verificadas (cartas_verificadas),
    .hubo_pareja        (hubo_pareja),
    .pairs_left         (pairs_left)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Random source: the polynomial x^16+x^14+x^13+x^11+1, stepping every clock.
  logic [15:0] lfsr_ref;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_ref <= 16'hACE1;
    else     lfsr_ref <= {lfsr_ref[14:0], ^(lfsr_ref & 16'hB400)};
  end

  int m_sym  [16];
  int m_stat [16];
  int m_pairs;

  logic [2:0] d_sym  [16];
  logic [1:0] d_stat [16];

  int vectors = 0;
  int errors  = 0;

  function automatic void model_ordered();
    for (int i = 0; i < 16; i++) begin
      m_sym[i]  = i / 2;
      m_stat[i] = HID;
    end
    m_pairs = 8;
  endfunction

  // Random HIDDEN slot other than excl, or -1 if none.
  function automatic int pick_hidden(input int excl);
    int start;
    start = $urandom_range(0, 15);
    for (int off = 0; off < 16; off++) begin
      int idx;
      idx = (start + off) % 16;
      if (m_stat[idx] == HID && idx != excl) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver / scoreboard tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic read_board();
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      d_sym[i]  = rd_sym;
      d_stat[i] = rd_status;
    end
  endtask

  task automatic check_board(input string tag);
    read_board();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_sym%0d", tag, i), 16'(d_sym[i]), 16'(m_sym[i]));
      check($sformatf("%s_stat%0d", tag, i), 16'(d_stat[i]), 16'(m_stat[i]));
    end
  endtask

  task automatic run_verify(input int a, input int b);
    logic match;
    match = (m_sym[a] == m_sym[b]);
    state = 4'd7;
    for (int k = 1; k <= VERIFY + 3; k++) begin
      tick();
      check($sformatf("verif_pulse_k%0d", k), 16'(cartas_verificadas), 16'(k == VERIFY + 1));
      check($sformatf("hubo_k%0d", k), 16'(hubo_pareja), (k == VERIFY + 1) ? 16'(match) : 16'd0);
    end
    if (match) begin
      m_stat[a] = MAT;
      m_stat[b] = MAT;
      if (m_pairs > 0) m_pairs--;
    end else begin
      m_stat[a] = HID;
      m_stat[b] = HID;
    end
    check("pairs_left", 16'(pairs_left), 16'(m_pairs));
  endtask

  // Player turn: pick a, try b while the first pulse is pending (must be
  // dropped), then pick b in UNA_CARTA and verify.
  task automatic do_turn(input int a, input int b);
    state = 4'd5; sel_idx = 4'(a); sel_valid = 1'b1;
    tick();
    check("turn_pick1", 16'(se_eligio_carta), 16'd1);
    sel_idx = 4'(b);
    tick();
    check("turn_pending_drop", 16'(se_eligio_carta), 16'd0);
    sel_valid = 1'b0; state = 4'd6;
    tick();
    check("turn_idle", 16'(se_eligio_carta), 16'd0);
    sel_valid = 1'b1;
    tick();
    check("turn_pick2", 16'(se_eligio_carta), 16'd1);
    sel_valid = 1'b0;
    m_stat[a] = FUP;
    m_stat[b] = FUP;
    run_verify(a, b);
  endtask

  task automatic fill_test(input int prior);
    int a, n_new, n_bad, pulses, seen_at;
    int p[2];
    state = 4'd4; tick();
    state = 4'd5; tick();
    p[0] = 0; p[1] = 0;
    if (prior != 0) begin
      a = pick_hidden(-1);
      sel_idx = 4'(a); sel_valid = 1'b1;
      tick();
      check("fill_prior_pick", 16'(se_eligio_carta), 16'd1);
      sel_valid = 1'b0;
      tick();
      m_stat[a] = FUP;
      p[0] = a;
    end
    state = 4'd8;
    pulses = 0; seen_at = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (carta_randomizada === 1'b1) begin
        pulses++;
        if (seen_at < 0) seen_at = k;
      end
      if (seen_at >= 0 && k >= seen_at + 4) break;
    end
    check("fill_pulses", 16'(pulses), 16'd1);
    read_board();
    n_new = 0; n_bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (int'(d_stat[i]) != m_stat[i]) begin
        if (m_stat[i] == HID && d_stat[i] == 2'(FUP) && (prior + n_new) < 2) begin
          p[prior + n_new] = i;
          n_new++;
        end else begin
          n_bad++;
        end
      end
    end
    check("fill_new_slots", 16'(n_new), 16'(2 - prior));
    check("fill_other_slots", 16'(n_bad), 16'd0);
    if (n_new == 2 - prior) begin
      for (int i = prior; i < 2; i++) m_stat[p[i]] = FUP;
      run_verify(p[0], p[1]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a, b, i_pos, cnt, nd;
    logic [3:0] j;
    logic mdone;

    rst = 1'b0; state = 4'd0; sel_valid = 1'b0; sel_idx = 4'd0; rd_idx = 4'd0;
    model_ordered();
    #1 rst = 1'b1;
    repeat (3) tick();

    // Reset values
    check("rst_mostradas", 16'(cartas_mostradas), 16'd0);
    check("rst_ocultas", 16'(cartas_ocultas), 16'd0);
    check("rst_revueltas", 16'(cartas_revueltas), 16'd0);
    check("rst_eligio", 16'(se_eligio_carta), 16'd0);
    check("rst_random", 16'(carta_randomizada), 16'd0);
    check("rst_verif", 16'(cartas_verificadas), 16'd0);
    check("rst_hubo", 16'(hubo_pareja), 16'd0);
    check("rst_pairs", 16'(pairs_left), 16'd8);
    check("rst_rd_sym", 16'(rd_sym), 16'd0);
    check("rst_rd_status", 16'(rd_status), 16'd0);
    rst = 1'b0;
    check_board("reset");

    // Preview: pulse on the fifth edge only
    state = 4'd1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("show_pulse_k%0d", k), 16'(cartas_mostradas), 16'(k == 5));
    end
    for (int i = 0; i < 16; i++) m_stat[i] = FUP;
    check_board("preview");
    check("show_no_repeat", 16'(cartas_mostradas), 16'd0);

    // Hide: pulse on the second edge
    state = 4'd2;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("hide_pulse_k%0d", k), 16'(cartas_ocultas), 16'(k == 2));
    end
    for (int i = 0; i < 16; i++) m_stat[i] = HID;
    check_board("hide");

    // Shuffle: Fisher-Yates on the model using the same random source
    state = 4'd3;
    tick();
    check("shuf_entry", 16'(cartas_revueltas), 16'd0);
    i_pos = 15; mdone = 1'b0;
    for (int n = 0; n < 600 && !mdone; n++) begin
      j = lfsr_ref[3:0];
      if (int'(j) <= i_pos) begin
        int t;
        t = m_sym[i_pos]; m_sym[i_pos] = m_sym[j]; m_sym[j] = t;
        if (i_pos == 1) mdone = 1'b1;
        else            i_pos--;
      end
      tick();
      check("shuf_pulse", 16'(cartas_revueltas), 16'(mdone));
    end
    check("shuf_budget", 16'(mdone), 16'd1);
    tick();
    check("shuf_no_repeat", 16'(cartas_revueltas), 16'd0);
    check_board("shuffled");
    for (int s = 0; s < 8; s++) begin
      cnt = 0;
      for (int i = 0; i < 16; i++) if (int'(d_sym[i]) == s) cnt++;
      check($sformatf("multiset_sym%0d", s), 16'(cnt), 16'd2);
    end
    nd = 0;
    for (int i = 0; i < 16; i++) if (int'(d_sym[i]) != i / 2) nd++;
    check("shuf_differs", 16'(nd != 0), 16'd1);

    // Matching pair chosen from the model
    state = 4'd4; tick();
    a = pick_hidden(-1);
    b = -1;
    for (int i = 0; i < 16; i++) if (i != a && m_sym[i] == m_sym[a]) b = i;
    do_turn(a, b);
    check_board("match");

    // Re-picking a MATCHED slot is ignored
    state = 4'd5; sel_idx = 4'(a); sel_valid = 1'b1;
    tick();
    check("repick_matched", 16'(se_eligio_carta), 16'd0);
    sel_valid = 1'b0;
    tick();
    check("repick_matched2", 16'(se_eligio_carta), 16'd0);

    // Deliberate mismatch
    a = pick_hidden(-1);
    b = -1;
    for (int i = 0; i < 16; i++)
      if (b < 0 && m_stat[i] == HID && m_sym[i] != m_sym[a]) b = i;
    do_turn(a, b);
    check_board("mismatch");

    // Random turns
    for (int t = 0; t < 3; t++) begin
      a = pick_hidden(-1);
      b = pick_hidden(a);
      do_turn(a, b);
    end
    check_board("random_turns");

    // Random completion with zero and one prior pick
    fill_test(0);
    check_board("fill0");
    fill_test(1);
    check_board("fill1");

    // Abandon a shuffle by returning to INICIO
    state = 4'd2; tick(); tick();
    state = 4'd3;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_shuf_pulse", 16'(cartas_revueltas), 16'd0);
    end
    state = 4'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_after_pulse", 16'(cartas_revueltas), 16'd0);
    end
    model_ordered();
    check("abort_pairs", 16'(pairs_left), 16'd8);
    check_board("abort");

    // Reset in the middle of a verification
    state = 4'd5; sel_idx = 4'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    state = 4'd6; sel_idx = 4'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; state = 4'd7;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rstmid_verif", 16'(cartas_verificadas), 16'd0);
    check("rstmid_hubo", 16'(hubo_pareja), 16'd0);
    check("rstmid_pairs", 16'(pairs_left), 16'd8);
    state = 4'd0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rstmid_no_verif", 16'(cartas_verificadas), 16'd0);
    end
    model_ordered();
    check_board("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
